// File: rtl/qenc_pkg.sv
// Shared definitions for the quadrature encoder counter: register offsets,
// CTRL/STATUS bit positions, address field widths and the x4 step decoder.
package qenc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CH_W   = 2;
    localparam int REG_W  = 2;

    typedef enum logic [REG_W-1:0] {
        REG_COUNT   = 2'd0,
        REG_CTRL    = 2'd1,
        REG_COMPARE = 2'd2,
        REG_RSVD    = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_INV   = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_ERR   = 8;
    localparam int CTRL_OVF   = 9;
    localparam int CTRL_MATCH = 10;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_e;

    // {A,B} forward sequence is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] fwd_next;
        case (prev)
            2'b00:   fwd_next = 2'b01;
            2'b01:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b10;
            default: fwd_next = 2'b00;
        endcase
        if (prev == cur)
            return STEP_NONE;
        if ((prev ^ cur) == 2'b11)
            return STEP_ERR;
        if (cur == fwd_next)
            return STEP_FWD;
        return STEP_REV;
    endfunction

endpackage

// File: rtl/quad_encoder_counter_if.sv
// Register bus between a host and the quadrature encoder counter.
interface quad_encoder_counter_if;
    import qenc_pkg::*;

    logic              rden;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport master (output rden, output wren, output addr, output din, input dout);
    modport slave  (input rden, input wren, input addr, input din, output dout);

endinterface

// File: rtl/qenc_channel.sv
// One encoder channel: synchronizer, x4 decoder, counter and its registers.
// Compare/MATCH logic exists only when QENC_COMPARE_EN is defined.
module qenc_channel
    import qenc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 wr_en,
    input  reg_sel_e             reg_sel,
    input  logic [CNT_WIDTH-1:0] wdata_cnt,
    input  logic [2:0]           wdata_cfg,
    input  logic [2:0]           wdata_w1c,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] compare,
    output logic [DATA_W-1:0]    ctrl_word,
    output logic                 irq_ch
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0] sync1, sync2, prev_ab;
    logic [1:0] hold_cnt;
    step_e      step_q;
    logic       en, inv, ie, err, ovf, match;

    logic                 fwd, rev, cnt_event, wrap;
    logic                 count_wr, ctrl_wr;
    logic [CNT_WIDTH-1:0] count_next;
    logic [2:0]           w1c;
    logic                 err_set, ovf_set, match_set;

    always_comb begin
        fwd        = 1'b0;
        rev        = 1'b0;
        count_next = count;
        wrap       = 1'b0;
        if (step_q == STEP_FWD) begin
            fwd = !inv;
            rev = inv;
        end else if (step_q == STEP_REV) begin
            fwd = inv;
            rev = !inv;
        end
        if (fwd) begin
            count_next = count + 1'b1;
            wrap       = (count == CNT_MAX);
        end else if (rev) begin
            count_next = count - 1'b1;
            wrap       = (count == '0);
        end
    end

    // A COUNT write wins over a same-cycle count event, which is then lost.
    assign count_wr  = wr_en && (reg_sel == REG_COUNT);
    assign ctrl_wr   = wr_en && (reg_sel == REG_CTRL);
    assign cnt_event = en && (fwd || rev) && !count_wr;
    assign w1c       = ctrl_wr ? wdata_w1c : 3'b000;
    assign err_set   = (step_q == STEP_ERR);
    assign ovf_set   = cnt_event && wrap;

`ifdef QENC_COMPARE_EN
    logic compare_wr;
    assign compare_wr = wr_en && (reg_sel == REG_COMPARE);
    assign match_set  = cnt_event && (count_next == compare);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            compare <= '0;
        else if (compare_wr)
            compare <= wdata_cnt;
    end
`else
    assign match_set = 1'b0;
    assign compare   = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            prev_ab  <= 2'b00;
            hold_cnt <= 2'd3;
            step_q   <= STEP_NONE;
            count    <= '0;
            en       <= 1'b1;
            inv      <= 1'b0;
            ie       <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
            match    <= 1'b0;
        end else begin
            sync1   <= {enc_a, enc_b};
            sync2   <= sync1;
            prev_ab <= sync2;
            // Hold off decoding until prev_ab has caught up with the pins.
            if (hold_cnt != 2'd0)
                hold_cnt <= hold_cnt - 2'd1;
            step_q <= (hold_cnt != 2'd0) ? STEP_NONE : decode_step(prev_ab, sync2);

            if (count_wr)
                count <= wdata_cnt;
            else if (cnt_event)
                count <= count_next;

            if (ctrl_wr) begin
                en  <= wdata_cfg[0];
                inv <= wdata_cfg[1];
                ie  <= wdata_cfg[2];
            end
            err   <= err_set   | (err   & ~w1c[0]);
            ovf   <= ovf_set   | (ovf   & ~w1c[1]);
            match <= match_set | (match & ~w1c[2]);
        end
    end

    always_comb begin
        ctrl_word             = '0;
        ctrl_word[CTRL_EN]    = en;
        ctrl_word[CTRL_INV]   = inv;
        ctrl_word[CTRL_IE]    = ie;
        ctrl_word[CTRL_ERR]   = err;
        ctrl_word[CTRL_OVF]   = ovf;
        ctrl_word[CTRL_MATCH] = match;
    end

    assign irq_ch = ie && (err || ovf || match);

endmodule

// File: rtl/quad_encoder_counter.sv
// Multi-channel quadrature encoder counter with a small register file.
// Define QENC_COMPARE_EN to enable the per-channel COMPARE/MATCH feature.
module quad_encoder_counter
    import qenc_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    quad_encoder_counter_if.slave       bus,
    input  logic [NUM_CH-1:0]           enc_a,
    input  logic [NUM_CH-1:0]           enc_b,
    output logic                        irq
);

    logic [CH_W-1:0]      ch_sel;
    reg_sel_e             reg_sel;
    logic [CNT_WIDTH-1:0] count_arr   [NUM_CH];
    logic [CNT_WIDTH-1:0] compare_arr [NUM_CH];
    logic [DATA_W-1:0]    ctrl_arr    [NUM_CH];
    logic [NUM_CH-1:0]    irq_vec;
    logic [DATA_W-1:0]    rdata;
    logic [2:0]           wdata_cfg, wdata_w1c;

    assign ch_sel    = bus.addr[ADDR_W-1:REG_W];
    assign reg_sel   = reg_sel_e'(bus.addr[REG_W-1:0]);
    assign wdata_cfg = {bus.din[CTRL_IE], bus.din[CTRL_INV], bus.din[CTRL_EN]};
    assign wdata_w1c = {bus.din[CTRL_MATCH], bus.din[CTRL_OVF], bus.din[CTRL_ERR]};

    // Channel indices beyond NUM_CH have no instance, so their writes fall away.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic wr_en;
        assign wr_en = bus.wren && (ch_sel == CH_W'(g));

        qenc_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .enc_a     (enc_a[g]),
            .enc_b     (enc_b[g]),
            .wr_en     (wr_en),
            .reg_sel   (reg_sel),
            .wdata_cnt (bus.din[CNT_WIDTH-1:0]),
            .wdata_cfg (wdata_cfg),
            .wdata_w1c (wdata_w1c),
            .count     (count_arr[g]),
            .compare   (compare_arr[g]),
            .ctrl_word (ctrl_arr[g]),
            .irq_ch    (irq_vec[g])
        );
    end

    always_comb begin
        rdata = '0;
        if (bus.rden && !reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == CH_W'(i)) begin
                    case (reg_sel)
                        REG_COUNT:   rdata = DATA_W'(count_arr[i]);
                        REG_CTRL:    rdata = ctrl_arr[i];
                        REG_COMPARE: rdata = DATA_W'(compare_arr[i]);
                        default:     rdata = '0;
                    endcase
                end
            end
        end
    end

    assign bus.dout = rdata;
    assign irq      = |irq_vec;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Randomized self-checking bench for quad_encoder_counter against a
// behavioural model of encoder position, counts and sticky flags.
module tb_quad_encoder_counter;

    localparam int          NCH  = 2;
    localparam int          W    = 16;
    localparam logic [31:0] MAXV = 32'h0000_FFFF;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] enc_a = '0;
    logic [NCH-1:0] enc_b = '0;
    logic           irq;

    quad_encoder_counter_if bus();

    quad_encoder_counter #(
        .NUM_CH    (NCH),
        .CNT_WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_cnt   [NCH];
    logic [31:0] m_cmp   [NCH];
    bit          m_en    [NCH];
    bit          m_inv   [NCH];
    bit          m_ie    [NCH];
    bit          m_err   [NCH];
    bit          m_ovf   [NCH];
    bit          m_match [NCH];
    int          m_pos   [NCH];
    logic [1:0]  gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int pos);
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_cmp[c] = 0; m_en[c] = 1; m_inv[c] = 0; m_ie[c] = 0;
            m_err[c] = 0; m_ovf[c] = 0; m_match[c] = 0; m_pos[c] = pos;
        end
    endtask

    task automatic model_count(input int ch, input int dir);
        int d;
        d = dir;
        if (!m_en[ch]) return;
        if (m_inv[ch]) d = -d;
        if (d > 0) begin
            if (m_cnt[ch] == MAXV) begin m_cnt[ch] = 0; m_ovf[ch] = 1; end
            else m_cnt[ch] = m_cnt[ch] + 1;
        end else begin
            if (m_cnt[ch] == 0) begin m_cnt[ch] = MAXV; m_ovf[ch] = 1; end
            else m_cnt[ch] = m_cnt[ch] - 1;
        end
`ifdef QENC_COMPARE_EN
        if (m_cnt[ch] == m_cmp[ch]) m_match[ch] = 1;
`endif
    endtask

    function automatic logic [31:0] exp_ctrl(input int ch);
        logic [31:0] r;
        r = 0;
        r[0] = m_en[ch]; r[1] = m_inv[ch]; r[2] = m_ie[ch];
        r[8] = m_err[ch]; r[9] = m_ovf[ch]; r[10] = m_match[ch];
        return r;
    endfunction

    function automatic logic [31:0] exp_irq();
        logic r;
        r = 0;
        for (int c = 0; c < NCH; c++)
            r = r | (m_ie[c] & (m_err[c] | m_ovf[c] | m_match[c]));
        return {31'b0, r};
    endfunction

    task automatic apply_inputs();
        for (int c = 0; c < NCH; c++) begin
            enc_a[c] = gray_tab[m_pos[c]][1];
            enc_b[c] = gray_tab[m_pos[c]][0];
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enc_step(input int ch, input int dir);
        @(posedge clk); #1;
        m_pos[ch] = (m_pos[ch] + ((dir > 0) ? 1 : 3)) % 4;
        apply_inputs();
        settle(6);
        model_count(ch, dir);
    endtask

    task automatic enc_glitch(input int ch);
        @(posedge clk); #1;
        m_pos[ch] = (m_pos[ch] + 2) % 4;
        apply_inputs();
        settle(6);
        m_err[ch] = 1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        int ch;
        @(negedge clk);
        bus.wren = 1'b1; bus.addr = a; bus.din = d;
        @(posedge clk); #1;
        bus.wren = 1'b0;
        ch = int'(a[3:2]);
        if (ch < NCH) begin
            case (a[1:0])
                2'd0: m_cnt[ch] = d & MAXV;
                2'd1: begin
                    m_en[ch] = d[0]; m_inv[ch] = d[1]; m_ie[ch] = d[2];
                    if (d[8])  m_err[ch]   = 0;
                    if (d[9])  m_ovf[ch]   = 0;
                    if (d[10]) m_match[ch] = 0;
                end
`ifdef QENC_COMPARE_EN
                2'd2: m_cmp[ch] = d & MAXV;
`endif
                default: ;
            endcase
        end
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.rden = 1'b1; bus.addr = a;
        #1;
        d = bus.dout;
        bus.rden = 1'b0;
    endtask

    task automatic check_ch(input int ch, input string tag);
        logic [31:0] d;
        bus_read(4'(ch * 4 + 0), d);
        check_val($sformatf("%s_count%0d", tag, ch), d, m_cnt[ch]);
        bus_read(4'(ch * 4 + 1), d);
        check_val($sformatf("%s_ctrl%0d", tag, ch), d, exp_ctrl(ch));
        bus_read(4'(ch * 4 + 2), d);
        check_val($sformatf("%s_compare%0d", tag, ch), d, m_cmp[ch]);
        check_val($sformatf("%s_irq", tag), {31'b0, irq}, exp_irq());
    endtask

    initial begin
        logic [31:0] d;
        int          ch, op;

        bus.rden = 1'b0; bus.wren = 1'b0; bus.addr = '0; bus.din = '0;
        model_reset(0);
        apply_inputs();
        settle(3);

        bus.rden = 1'b1; bus.addr = 4'h1;
        #1;
        check_val("dout_in_reset", bus.dout, 32'h0);
        check_val("irq_in_reset", {31'b0, irq}, 32'h0);
        bus.rden = 1'b0;
        @(negedge clk) reset = 1'b0;
        settle(5);
        check_ch(0, "reset");
        check_ch(1, "reset");

        @(negedge clk); bus.addr = 4'h1; bus.rden = 1'b0; #1;
        check_val("dout_rden0", bus.dout, 32'h0);
        bus_read(4'h3, d);
        check_val("reserved_read", d, 32'h0);
        bus_write(4'h3, 32'hFFFF_FFFF);
        bus_write(4'hC, 32'h0000_1234);
        bus_write(4'hD, 32'h0000_0007);
        bus_read(4'hC, d);
        check_val("absent_ch_count", d, 32'h0);
        bus_read(4'hD, d);
        check_val("absent_ch_ctrl", d, 32'h0);
        check_ch(0, "after_ignored_writes");

        // Four forward steps on ch0 only.
        repeat (4) enc_step(0, 1);
        bus_read(4'h0, d);
        check_val("fwd4_count0", d, 32'd4);
        check_ch(0, "fwd4");
        check_ch(1, "fwd4");

        // Underflow wrap and OVF write-1-clear.
        bus_write(4'h0, 32'h0);
        enc_step(0, -1);
        bus_read(4'h0, d);
        check_val("underflow_count0", d, 32'h0000_FFFF);
        check_ch(0, "underflow");
        bus_write(4'h1, 32'h0000_0200);
        check_ch(0, "ovf_clr");
        enc_step(0, 1);
        check_ch(0, "frozen");
        bus_write(4'h1, 32'h0000_0001);

        // Simultaneous A/B toggle on ch1.
        enc_glitch(1);
        check_ch(1, "glitch");
        bus_write(4'h5, 32'h0000_0005);
        check_val("glitch_irq", {31'b0, irq}, 32'h1);
        check_ch(1, "glitch_ie");
        bus_write(4'h5, 32'h0000_0105);
        check_ch(1, "err_clr");

        // Input change just after edge E0 shows in the counter after E0+4.
        @(posedge clk); #1;
        m_pos[0] = (m_pos[0] + 1) % 4;
        apply_inputs();
        repeat (3) @(posedge clk);
        bus_read(4'h0, d);
        check_val("latency_before", d, m_cnt[0]);
        @(posedge clk);
        model_count(0, 1);
        bus_read(4'h0, d);
        check_val("latency_after", d, m_cnt[0]);
        settle(4);

        // COUNT write in the same cycle the step lands.
        @(posedge clk); #1;
        m_pos[0] = (m_pos[0] + 1) % 4;
        apply_inputs();
        repeat (3) @(posedge clk);
        bus_write(4'h0, 32'h0000_0005);
        settle(4);
        bus_read(4'h0, d);
        check_val("write_priority", d, 32'd5);
        check_ch(0, "write_priority");

        // Compare / MATCH.
        bus_write(4'h0, 32'h0);
        bus_write(4'h2, 32'h3);
        bus_write(4'h1, 32'h0000_0705);
        repeat (3) enc_step(0, 1);
        bus_read(4'h1, d);
`ifdef QENC_COMPARE_EN
        check_val("match_bit", {31'b0, d[10]}, 32'h1);
        check_val("match_irq", {31'b0, irq}, 32'h1);
`else
        check_val("match_bit", {31'b0, d[10]}, 32'h0);
        bus_read(4'h2, d);
        check_val("compare_reads0", d, 32'h0);
`endif
        check_ch(0, "match");
        bus_write(4'h1, 32'h0000_0701);

        for (int it = 0; it < 150; it++) begin
            ch = $urandom_range(0, NCH - 1);
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: enc_step(ch, 1);
                4, 5:       enc_step(ch, -1);
                6:          enc_glitch(ch);
                7: begin
                    d = 32'($urandom_range(0, 7)) << 8;
                    d = d | 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                    bus_write(4'(ch * 4 + 1), d);
                end
                8: begin
                    case ($urandom_range(0, 3))
                        0:       d = 32'h0;
                        1:       d = MAXV;
                        2:       d = MAXV - 1;
                        default: d = $urandom;
                    endcase
                    bus_write(4'(ch * 4 + 0), d);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        bus_write(4'(ch * 4 + 2), 32'($urandom_range(0, 8)) | ($urandom & 32'hFFFF_0000));
                    else
                        bus_write(4'(12 + $urandom_range(0, 3)), $urandom);
                end
            endcase
            check_ch(ch, $sformatf("rand%0d", it));
        end

        // Reset asserted mid-transition with both phases going high and held.
        @(posedge clk); #1;
        enc_a = '1; enc_b = '1;
        #2 reset = 1'b1;
        model_reset(2);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus_read(4'h0, d);
            check_val($sformatf("static_high_count0_%0d", k), d, 32'h0);
            bus_read(4'h4, d);
            check_val($sformatf("static_high_count1_%0d", k), d, 32'h0);
        end
        check_ch(0, "static_high");
        check_ch(1, "static_high");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_encoder_counter.md
QUAD_ENCODER_COUNTER -- requirements
Module: quad_encoder_counter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent encoder channels (legal 1..4).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the counter width in bits (legal 8..32).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port rden  input  1  read enable for dout.
REQ-006 The block SHALL have port wren  input  1  write strobe; the addressed register is written on the rising clk edge while high.
REQ-007 The block SHALL have port addr  input  4  register address: addr[3:2] selects the channel, addr[1:0] selects the register.
REQ-008 The block SHALL have port din  input  32  write data.
REQ-009 The block SHALL have port dout  output  32  read data; combinational from addr/rden.
REQ-010 The block SHALL have port enc_a  input  NUM_CH  asynchronous quadrature phase A, one bit per channel.
REQ-011 The block SHALL have port enc_b  input  NUM_CH  asynchronous quadrature phase B, one bit per channel.
REQ-012 The block SHALL have port irq  output  1  OR of all enabled per-channel interrupt sources.

Function
REQ-013 Each channel SHALL pass enc_a/enc_b through a 2-flop synchronizer and then compare the result against a registered previous {A,B} state.
REQ-014 Decoding SHALL be x4 quadrature: Gray sequences 00->01->11->10->00 SHALL count +1, the reverse sequence SHALL count -1, and no change SHALL count 0.
REQ-015 A transition in which A and B change in the same sample SHALL count 0 and SHALL set the sticky ERR bit.
REQ-016 When control bit INV is 1, the count direction SHALL be inverted.
REQ-017 Counting SHALL occur only while control bit EN is 1; with EN at 0 the counter SHALL be frozen, while prev-state tracking and ERR detection SHALL continue.
REQ-018 Counter arithmetic SHALL be modulo 2^CNT_WIDTH (max+1 -> 0; 0-1 -> max); a wrap SHALL set the sticky OVF bit.
REQ-019 Latency: an input change stable before clk edge N SHALL be reflected in the counter after edge N+3.
REQ-020 Register map per channel: 0 = COUNT (RW); 1 = CTRL/STATUS; 2 = COMPARE (RW, CNT_WIDTH bits); 3 = reserved (reads 0, writes ignored).
REQ-021 CTRL/STATUS bit layout: bit0 EN (RW); bit1 INV (RW); bit2 IE (RW, interrupt enable); bit8 ERR (sticky, write-1-clear); bit9 OVF (sticky, W1C); bit10 MATCH (sticky, W1C).
REQ-022 dout SHALL return the addressed value zero-extended to 32 bits while rden=1, and 0 while rden=0, for reserved registers, or for channel index >= NUM_CH.
REQ-023 Writes to channel index >= NUM_CH SHALL be ignored.
REQ-024 A COUNT write SHALL take priority over a same-cycle count event, and the event SHALL be dropped; din bits above CNT_WIDTH SHALL be ignored.
REQ-025 A sticky bit set event SHALL take priority over a same-cycle W1C of that bit.
REQ-026 Per channel, irq_ch SHALL equal IE AND (ERR OR OVF OR MATCH); irq SHALL be the OR of all irq_ch and SHALL be combinational from the registered state.

Reset
REQ-027 Reset SHALL set COUNT=0, COMPARE=0, EN=1, INV=0, IE=0, all sticky bits=0, and synchronizer/prev flops=0; dout=0 and irq=0 during reset.
REQ-028 After reset deassertion, counting and ERR detection SHALL be suppressed for 3 clocks while prev state loads, so a static high input causes no count.
REQ-029 Reset asserted mid-transition SHALL discard any in-flight edge.

Configuration
REQ-030 With macro QENC_COMPARE_EN defined, MATCH SHALL set on the cycle the counter is updated to equal COMPARE (by counting, not by a COUNT write).
REQ-031 Without QENC_COMPARE_EN, the COMPARE register SHALL read 0 and ignore writes, and MATCH SHALL read 0 and never set.

Structure
REQ-032 Package qenc_pkg SHALL hold the register offsets (REG_COUNT, REG_CTRL, REG_COMPARE), the CTRL bit positions, and the address field widths.
REQ-033 Sub-module qenc_channel SHALL contain the synchronizer, decoder, counter, and per-channel registers; the top SHALL instantiate NUM_CH copies plus address decode, dout mux, and irq OR.

Verification
REQ-034 Reset, then drive 4 forward Gray steps on ch0 -> COUNT0 reads 4, and ch1 COUNT reads 0.
REQ-035 Write COUNT0=0, then apply 1 reverse step -> COUNT0 reads 0xFFFF and OVF=1; write 0x200 to CTRL0 -> OVF=0.
REQ-036 Toggle A and B together on ch1 -> COUNT1 unchanged, ERR=1; set IE -> irq=1.
REQ-037 Hold enc_a=enc_b=1 through reset release -> COUNT stays 0 for 10 clocks.
REQ-038 Write COUNT0=5 on the same cycle a forward step is decoded -> COUNT0 reads 5.
REQ-039 With QENC_COMPARE_EN defined, set COMPARE0=3, IE=1, apply 3 forward steps -> MATCH=1 and irq=1; without the macro, the same stimulus -> MATCH=0 and COMPARE reads 0.
